// File: rtl/sdram_burst_model.sv
// sdram_burst_model: parametrised SDRAM behavioural model.
// Decodes the multiplexed row/column address and ras/cas/we/ce command pins,
// runs read/write bursts with programmable burst length and wrap type, a
// CAS-latency read path and a tri-state data bus.
// Optional feature macro: SDRAM_DQM_EN adds the dqm byte-mask input.
//
// Burst engine: a single engine serves both directions. A burst command
// arms a latency countdown; once it expires one beat is executed per edge.
// The beat due at the edge a new command is sampled still completes; the
// command then takes effect (restart, precharge). An accepted WRITE turns the
// bus around at once, so the read beat due on that same edge is not driven.
module sdram_burst_model #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int CAS_LATENCY   = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset_not,
    input  logic [ADDR_WIDTH-1:0] partial_address_bus,
    input  logic                  chip_enable_not,
    input  logic                  ras_not,
    input  logic                  cas_not,
    input  logic                  write_not,
`ifdef SDRAM_DQM_EN
    input  logic                  dqm,
`endif
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int WORD_AW = 2 * ADDR_WIDTH;
    localparam int DEPTH   = 1 << WORD_AW;
    localparam logic [1:0] CL_INIT = 2'(CAS_LATENCY - 1);
    localparam logic [1:0] WL_INIT = 2'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_READ_BURST,
        ST_WRITE_BURST
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACTIVATE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_LOAD_MODE
    } cmd_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [1:0]            bl_code_q, bl_code_d;
    logic                  linear_q, linear_d;
    logic [ADDR_WIDTH-1:0] start_col_q, start_col_d;
    logic [2:0]            beat_q, beat_d;
    logic [1:0]            wait_q, wait_d;
    logic                  rd_drive_q, rd_drive_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]            dqm_pipe_q, dqm_pipe_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    cmd_e                  cmd;
    logic                  dqm_now;
    logic [2:0]            bl_last;
    logic [ADDR_WIDTH-1:0] bl_mask;
    logic [ADDR_WIDTH-1:0] beat_sum;
    logic [ADDR_WIDTH-1:0] beat_col;
    logic [WORD_AW-1:0]    beat_addr;
    logic                  mem_we;

`ifdef SDRAM_DQM_EN
    assign dqm_now = dqm;
`else
    assign dqm_now = 1'b0;
`endif

    // Command decode from the strobe pins; deselect is a NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (!chip_enable_not) begin
            unique case ({ras_not, cas_not, write_not})
                3'b011:  cmd = CMD_ACTIVATE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b000:  cmd = CMD_LOAD_MODE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Beat address: last beat index from the burst-length code, then
    // sequential (wrap inside the BL-aligned block) or linear column order.
    always_comb begin
        unique case (bl_code_q)
            2'd0:    bl_last = 3'd0;
            2'd1:    bl_last = 3'd1;
            2'd2:    bl_last = 3'd3;
            default: bl_last = 3'd7;
        endcase
        bl_mask   = ADDR_WIDTH'(bl_last);
        beat_sum  = start_col_q + ADDR_WIDTH'(beat_q);
        beat_col  = linear_q ? beat_sum
                             : ((start_col_q & ~bl_mask) | (beat_sum & bl_mask));
        beat_addr = {row_q, beat_col};
    end

    // Next-state logic: run the current beat, then apply the sampled command.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d     = state_q;
        row_d       = row_q;
        bl_code_d   = bl_code_q;
        linear_d    = linear_q;
        start_col_d = start_col_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        rd_drive_d  = 1'b0;
        rd_data_d   = rd_data_q;
        dqm_pipe_d  = {dqm_pipe_q[0], dqm_now};
        mem_we      = 1'b0;

        if (state_q == ST_READ_BURST || state_q == ST_WRITE_BURST) begin
            if (wait_q != 2'd0) begin
                wait_d = wait_q - 2'd1;
            end else begin
                if (state_q == ST_WRITE_BURST) begin
                    mem_we = !dqm_now;
                end else begin
                    // Mask sampled two edges earlier blanks this read beat.
                    rd_drive_d = !dqm_pipe_q[1];
                    rd_data_d  = mem_q[beat_addr];
                end
                if (beat_q == bl_last) begin
                    state_d = ST_ACTIVE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
        end

        if (state_q == ST_IDLE) begin
            if (cmd == CMD_ACTIVATE) begin
                row_d   = partial_address_bus;
                state_d = ST_ACTIVE;
            end else if (cmd == CMD_LOAD_MODE) begin
                bl_code_d = partial_address_bus[1:0];
                linear_d  = partial_address_bus[2];
            end
        end else begin
            unique case (cmd)
                CMD_READ: begin
                    state_d     = ST_READ_BURST;
                    start_col_d = partial_address_bus;
                    beat_d      = 3'd0;
                    wait_d      = CL_INIT;
                end
                CMD_WRITE: begin
                    state_d     = ST_WRITE_BURST;
                    start_col_d = partial_address_bus;
                    beat_d      = 3'd0;
                    wait_d      = WL_INIT;
                    rd_drive_d  = 1'b0;
                end
                CMD_PRECHARGE: begin
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_not) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            bl_code_q   <= 2'd2;
            linear_q    <= 1'b0;
            start_col_q <= '0;
            beat_q      <= 3'd0;
            wait_q      <= 2'd0;
            rd_drive_q  <= 1'b0;
            rd_data_q   <= '0;
            dqm_pipe_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            bl_code_q   <= bl_code_d;
            linear_q    <= linear_d;
            start_col_q <= start_col_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            rd_drive_q  <= rd_drive_d;
            rd_data_q   <= rd_data_d;
            dqm_pipe_q  <= dqm_pipe_d;
        end
    end

    // Storage array write port; a reset edge aborts the beat due on it.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset; contents survive reset_not.
        if (mem_we && reset_not) begin
            mem_q[beat_addr] <= data;
        end
    end

    assign data = rd_drive_q ? rd_data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sdram_burst_model.sv
// Testbench for sdram_burst_model: directed steps plus a random command
// stream, checked every cycle against an event-list reference model.
module tb_sdram_burst_model;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CL = 2;
    localparam int WL = 2;
    localparam int WA = 2 * AW;

    typedef enum {C_NOP, C_ACT, C_READ, C_WRITE, C_PRE, C_LMR, C_DESEL} cmd_e;

    typedef struct {
        int            t;
        bit            wr;
        logic [WA-1:0] addr;
        logic [DW-1:0] val;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset_not = 1'b0;
    logic          chip_enable_not = 1'b1;
    logic          ras_not = 1'b1;
    logic          cas_not = 1'b1;
    logic          write_not = 1'b1;
    logic [AW-1:0] pab = '0;
`ifdef SDRAM_DQM_EN
    logic          dqm = 1'b0;
`endif
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_wdata = '0;
    wire  [DW-1:0] data;

    assign data = tb_drv ? tb_wdata : {DW{1'bz}};

    always #5 clock = ~clock;

    sdram_burst_model #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .CAS_LATENCY  (CL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clock              (clock),
        .reset_not          (reset_not),
        .partial_address_bus(pab),
        .chip_enable_not    (chip_enable_not),
        .ras_not            (ras_not),
        .cas_not            (cas_not),
        .write_not          (write_not),
`ifdef SDRAM_DQM_EN
        .dqm                (dqm),
`endif
        .data               (data)
    );

    // Reference model: open-row flag, mode, word array and a list of
    // scheduled beats (edge number, direction, word address, write value).
    ev_t           ev_q[$];
    logic [DW-1:0] m_mem [1 << WA];
    bit            m_open = 1'b0;
    logic [AW-1:0] m_row = '0;
    int            m_bl = 4;
    bit            m_lin = 1'b0;
    bit            dqm_log[int];
    logic [DW-1:0] wr_vals[8];
    int            edge_n = 0;
    int            errors = 0;
    int            checks = 0;

    task automatic model_edge(input cmd_e c, input logic [AW-1:0] a, input bit rst,
                              input bit dq, output logic [DW-1:0] exp);
        int col;
        int lat;
        exp = {DW{1'bz}};
        if (rst) begin
            ev_q.delete();
            m_open = 1'b0;
            m_bl   = 4;
            m_lin  = 1'b0;
            dqm_log[edge_n]     = 1'b0;
            dqm_log[edge_n - 1] = 1'b0;
            return;
        end
        dqm_log[edge_n] = dq;
        for (int k = ev_q.size() - 1; k >= 0; k--) begin
            if (ev_q[k].t == edge_n) begin
                if (ev_q[k].wr) begin
                    if (!dq) m_mem[ev_q[k].addr] = ev_q[k].val;
                end else if (!(dqm_log.exists(edge_n - 2) && dqm_log[edge_n - 2])) begin
                    exp = m_mem[ev_q[k].addr];
                end
                ev_q.delete(k);
            end
        end
        if (!m_open) begin
            if (c == C_ACT) begin
                m_row  = a;
                m_open = 1'b1;
            end else if (c == C_LMR) begin
                m_bl  = 1 << a[1:0];
                m_lin = a[2];
            end
        end else if (c == C_READ || c == C_WRITE) begin
            ev_q.delete();
            lat = (c == C_READ) ? CL : WL;
            for (int i = 0; i < m_bl; i++) begin
                if (m_lin) col = (int'(a) + i) % (1 << AW);
                else       col = (int'(a) & ~(m_bl - 1)) | ((int'(a) + i) & (m_bl - 1));
                ev_q.push_back('{t: edge_n + lat + i, wr: (c == C_WRITE),
                                 addr: {m_row, AW'(col)}, val: wr_vals[i]});
            end
            if (c == C_WRITE) exp = {DW{1'bz}};
        end else if (c == C_PRE) begin
            ev_q.delete();
            m_open = 1'b0;
        end
    endtask

    // One clock: drive pins (and any write beat due) at the falling edge,
    // update the model at the rising edge, compare the bus 2 time units later.
    task automatic tick(input cmd_e c, input logic [AW-1:0] a, input bit rst,
                        input bit dq, input string tag);
        logic [DW-1:0] exp;
        @(negedge clock);
        reset_not       = ~rst;
        pab             = a;
        chip_enable_not = 1'b0;
`ifdef SDRAM_DQM_EN
        dqm = dq;
`endif
        unique case (c)
            C_NOP:   {ras_not, cas_not, write_not} = 3'b111;
            C_ACT:   {ras_not, cas_not, write_not} = 3'b011;
            C_READ:  {ras_not, cas_not, write_not} = 3'b101;
            C_WRITE: {ras_not, cas_not, write_not} = 3'b100;
            C_PRE:   {ras_not, cas_not, write_not} = 3'b010;
            C_LMR:   {ras_not, cas_not, write_not} = 3'b000;
            default: begin
                chip_enable_not = 1'b1;
                {ras_not, cas_not, write_not} = 3'b101;
            end
        endcase
        tb_drv = 1'b0;
        foreach (ev_q[k]) begin
            if (ev_q[k].t == edge_n + 1 && ev_q[k].wr) begin
                tb_drv   = 1'b1;
                tb_wdata = ev_q[k].val;
            end
        end
        @(posedge clock);
        edge_n++;
        model_edge(c, a, rst, dq, exp);
        #1 tb_drv = 1'b0;
        #1;
        checks++;
        assert (data === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d data=%h expected=%h", tag, edge_n, data, exp);
        end
    endtask

    task automatic cmd(input cmd_e c, input logic [AW-1:0] a, input string tag);
        tick(c, a, 1'b0, 1'b0, tag);
    endtask

    task automatic nops(input int n, input string tag);
        repeat (n) tick(C_NOP, '0, 1'b0, 1'b0, tag);
    endtask

    task automatic set_vals4(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                             input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        wr_vals[0] = v0; wr_vals[1] = v1; wr_vals[2] = v2; wr_vals[3] = v3;
        for (int i = 4; i < 8; i++) wr_vals[i] = '0;
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 8; i++) wr_vals[i] = DW'($urandom);
    endtask

    initial begin
        int   r;
        cmd_e c;
        bit   rst;
        bit   dq;

        set_vals4('0, '0, '0, '0);

        // Reset state: bus released.
        tick(C_NOP, '0, 1'b1, 1'b0, "reset");
        tick(C_NOP, '0, 1'b1, 1'b0, "reset");
        nops(1, "post_reset");

        // Basic write then read-back; ACTIVATE while a row is open is ignored.
        cmd(C_ACT, 4'd3, "t1_act");
        set_vals4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        cmd(C_WRITE, 4'd2, "t1_write");
        nops(6, "t1_write_beats");
        cmd(C_ACT, 4'd3, "t1_act_ignored");
        cmd(C_ACT, 4'd5, "t1_act_other_ignored");
        cmd(C_READ, 4'd2, "t1_read");
        nops(7, "t1_read_beats");

        // Sequential BL4 write from column 6, read back per column with BL1.
        cmd(C_PRE, '0, "t2_pre");
        cmd(C_LMR, 4'b0010, "t2_lmr_seq");
        cmd(C_ACT, 4'd3, "t2_act");
        set_vals4(8'h11, 8'h22, 8'h33, 8'h44);
        cmd(C_WRITE, 4'd6, "t2_write_seq");
        nops(6, "t2_write_beats");
        cmd(C_PRE, '0, "t2_pre");
        cmd(C_LMR, 4'b0000, "t2_lmr_bl1");
        cmd(C_ACT, 4'd3, "t2_act");
        for (int col = 4; col < 8; col++) begin
            cmd(C_READ, AW'(col), "t2_read_seq_col");
            nops(3, "t2_read_seq_beat");
        end

        // Same with linear wrap: columns 6,7,8,9.
        cmd(C_PRE, '0, "t2_pre");
        cmd(C_LMR, 4'b0110, "t2_lmr_lin");
        cmd(C_ACT, 4'd3, "t2_act");
        set_vals4(8'h55, 8'h66, 8'h77, 8'h88);
        cmd(C_WRITE, 4'd6, "t2_write_lin");
        nops(6, "t2_write_beats");
        cmd(C_PRE, '0, "t2_pre");
        cmd(C_LMR, 4'b0000, "t2_lmr_bl1");
        cmd(C_ACT, 4'd3, "t2_act");
        for (int col = 4; col < 10; col++) begin
            cmd(C_READ, AW'(col), "t2_read_lin_col");
            nops(3, "t2_read_lin_beat");
        end

        // READ with no open row is ignored; then a single-beat burst.
        cmd(C_PRE, '0, "t3_pre");
        cmd(C_READ, 4'd0, "t3_read_idle");
        nops(8, "t3_idle_hiz");
        cmd(C_LMR, 4'b0000, "t3_lmr_bl1");
        cmd(C_ACT, 4'd3, "t3_act");
        cmd(C_READ, 4'd2, "t3_read_bl1");
        nops(4, "t3_bl1_beat");

        // BL8: fill columns 8..15, then precharge mid-read.
        cmd(C_PRE, '0, "t4_pre");
        cmd(C_LMR, 4'b0011, "t4_lmr_bl8");
        cmd(C_ACT, 4'd3, "t4_act");
        rand_vals();
        cmd(C_WRITE, 4'd8, "t4_fill");
        nops(10, "t4_fill_beats");
        cmd(C_READ, 4'd0, "t4_read");
        nops(2, "t4_first_beat");
        cmd(C_PRE, '0, "t4_pre_mid_burst");
        nops(4, "t4_after_pre");
        cmd(C_READ, 4'd0, "t4_read_after_pre");
        nops(4, "t4_idle_hiz");

        // Read interrupted after two beats by a read from column 8.
        cmd(C_ACT, 4'd3, "t5_act");
        cmd(C_READ, 4'd0, "t5_read");
        nops(2, "t5_first_beats");
        cmd(C_READ, 4'd8, "t5_reread");
        nops(12, "t5_second_burst");

        // Reset during a write burst: two beats land, the rest do not.
        rand_vals();
        cmd(C_WRITE, 4'd0, "t6_write");
        nops(3, "t6_write_beats");
        tick(C_NOP, '0, 1'b1, 1'b0, "t6_reset");
        nops(1, "t6_post_reset");
        cmd(C_ACT, 4'd3, "t6_act");
        cmd(C_READ, 4'd0, "t6_read_bl4");
        nops(6, "t6_read_beats");
        cmd(C_READ, 4'd6, "t6_read_seq");
        nops(6, "t6_seq_beats");

`ifdef SDRAM_DQM_EN
        // Write mask on beat 2, then read mask on beat 1.
        cmd(C_PRE, '0, "t7_pre");
        cmd(C_LMR, 4'b0010, "t7_lmr");
        cmd(C_ACT, 4'd5, "t7_act");
        rand_vals();
        cmd(C_WRITE, 4'd0, "t7_old");
        nops(6, "t7_old_beats");
        set_vals4(8'h01, 8'h02, 8'h03, 8'h04);
        cmd(C_WRITE, 4'd0, "t7_write");
        nops(3, "t7_write_beats");
        tick(C_NOP, '0, 1'b0, 1'b1, "t7_dqm_write");
        nops(3, "t7_write_tail");
        cmd(C_READ, 4'd0, "t7_readback");
        nops(6, "t7_readback_beats");
        cmd(C_READ, 4'd0, "t7_read_mask");
        tick(C_NOP, '0, 1'b0, 1'b1, "t7_dqm_read");
        nops(5, "t7_read_mask_beats");
`endif

        // Random command stream.
        for (int n = 0; n < 500; n++) begin
            r   = $urandom_range(0, 99);
            rst = 1'b0;
            dq  = 1'b0;
`ifdef SDRAM_DQM_EN
            dq = ($urandom_range(0, 7) == 0);
`endif
            if      (r == 0)  begin c = C_NOP; rst = 1'b1; end
            else if (r < 16)  c = C_NOP;
            else if (r < 26)  c = C_DESEL;
            else if (r < 41)  c = C_ACT;
            else if (r < 59)  c = C_READ;
            else if (r < 77)  c = C_WRITE;
            else if (r < 87)  c = C_PRE;
            else              c = C_LMR;
            rand_vals();
            tick(c, AW'($urandom), rst, dq, "rand");
        end
        nops(12, "rand_flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
